// File: rtl/lsu_mem_access_ctrl.sv
// Load/store access controller between the MEM stage and the data-memory bus.
// Decodes size/sign, issues one or two aligned beats over req/gnt/rvalid and merges/extends the load result.
module lsu_mem_access_ctrl #(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int MISALIGN_EN = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   output logic              resp_valid_o,
   output logic [XLEN-1:0]   resp_rdata_o,
   output logic              resp_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              mem_err_i
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP} state_t;

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         3'b000, 3'b001, 3'b010: ok = 1'b1;
         3'b011:                 ok = (XLEN == 64);
         3'b100, 3'b101:         ok = ~we;
         3'b110:                 ok = ~we && (XLEN == 64);
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   // funct3[1:0] encodes log2 of the access size for every legal code.
   function automatic logic [3:0] f3_size(input logic [2:0] f3);
      return 4'd1 << f3[1:0];
   endfunction

   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [3:0] n,
                                             input logic sgn);
      logic [XLEN-1:0] r;
      logic            top;
      top = 1'b0;
      r   = '0;
      for (int i = 0; i < XLEN; i++)
         if (i == 8 * int'(n) - 1) top = v[i];
      for (int i = 0; i < XLEN; i++)
         r[i] = (i < 8 * int'(n)) ? v[i] : (sgn & top);
      return r;
   endfunction

   state_t              state, next_state;
   logic                we_q, err_q;
   logic [2:0]          f3_q;
   logic [ADDR_W-1:0]   addr_q, aligned;
   logic [XLEN-1:0]     wdata_q, rbuf_q;
   logic [OW-1:0]       off;
   logic [OW:0]         k;
   logic [3:0]          size_q;
   logic                split_q, split_in, fast_err_in, accept;
   logic [2*NB-1:0]     mask;
   logic [2*XLEN-1:0]   wide_wd;

   assign accept      = req_valid_i && (state == IDLE);
   assign split_in    = (int'(req_addr_i[OW-1:0]) + int'(f3_size(req_funct3_i))) > NB;
   assign fast_err_in = !f3_legal(req_we_i, req_funct3_i) || (split_in && (MISALIGN_EN == 0));

   assign size_q  = f3_size(f3_q);
   assign off     = addr_q[OW-1:0];
   assign k       = (OW+1)'(NB) - (OW+1)'(off);
   assign split_q = (int'(off) + int'(size_q)) > NB;
   assign aligned = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
   // Low halves feed beat 1, high halves (bytes spilling past the word) feed beat 2.
   assign mask    = (((2*NB)'(1) << size_q) - (2*NB)'(1)) << off;
   assign wide_wd = {{XLEN{1'b0}}, wdata_q} << (8 * off);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         err_q <= 1'b0;
      end else begin
         state <= next_state;
         if (accept)
            err_q <= fast_err_in;
         else if (state == WAIT1 && mem_rvalid_i)
            err_q <= mem_err_i;
         else if (state == WAIT2 && mem_rvalid_i)
            err_q <= err_q | mem_err_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         we_q    <= req_we_i;
         f3_q    <= req_funct3_i;
         addr_q  <= req_addr_i;
         wdata_q <= req_wdata_i;
      end
      if (state == WAIT1 && mem_rvalid_i)
         rbuf_q <= mem_rdata_i >> (8 * off);
      else if (state == WAIT2 && mem_rvalid_i)
         rbuf_q <= rbuf_q | (mem_rdata_i << (8 * k));
   end

   always_comb begin
      next_state   = state;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_rdata_o = '0;
      resp_err_o   = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_be_o     = '0;
      mem_wdata_o  = '0;
      case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) next_state = fast_err_in ? RESP : ISSUE1;
         end
         ISSUE1: begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = aligned;
            mem_be_o    = mask[NB-1:0];
            mem_wdata_o = wide_wd[XLEN-1:0];
            if (mem_gnt_i) next_state = WAIT1;
         end
         WAIT1: begin
            if (mem_rvalid_i) next_state = (!mem_err_i && split_q) ? ISSUE2 : RESP;
         end
         ISSUE2: begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = aligned + ADDR_W'(NB);
            mem_be_o    = mask[2*NB-1:NB];
            mem_wdata_o = wide_wd[2*XLEN-1:XLEN];
            if (mem_gnt_i) next_state = WAIT2;
         end
         WAIT2: begin
            if (mem_rvalid_i) next_state = RESP;
         end
         RESP: begin
            resp_valid_o = 1'b1;
            resp_err_o   = err_q;
            if (!err_q && !we_q) resp_rdata_o = extend(rbuf_q, size_q, ~f3_q[2]);
            next_state   = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end
endmodule

// File: tb/tb_lsu_mem_access_ctrl.sv
// Directed bench for lsu_mem_access_ctrl: a 32-bit misalign-splitting instance and a 64-bit
// misalign-rejecting instance share one stimulus/scoreboard path, selected by sel.
module tb_lsu_mem_access_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0, we = 1'b0, gnt = 1'b0, rvalid = 1'b0, berr = 1'b0;
   logic [2:0]  f3 = '0;
   logic [31:0] addr = '0;
   logic [63:0] wdata = '0, rdata = '0;

   logic        a_ready, a_resp_valid, a_resp_err, a_mem_req, a_mem_we;
   logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_be;
   logic        b_ready, b_resp_valid, b_resp_err, b_mem_req, b_mem_we;
   logic [63:0] b_resp_rdata, b_mem_wdata;
   logic [31:0] b_mem_addr;
   logic [7:0]  b_mem_be;

   lsu_mem_access_ctrl #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid & ~sel), .req_ready_o(a_ready),
      .req_we_i(we), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata[31:0]),
      .resp_valid_o(a_resp_valid), .resp_rdata_o(a_resp_rdata), .resp_err_o(a_resp_err),
      .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_be_o(a_mem_be),
      .mem_wdata_o(a_mem_wdata), .mem_gnt_i(gnt & ~sel), .mem_rvalid_i(rvalid & ~sel),
      .mem_rdata_i(rdata[31:0]), .mem_err_i(berr));

   lsu_mem_access_ctrl #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(0)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid & sel), .req_ready_o(b_ready),
      .req_we_i(we), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata),
      .resp_valid_o(b_resp_valid), .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err),
      .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_be_o(b_mem_be),
      .mem_wdata_o(b_mem_wdata), .mem_gnt_i(gnt & sel), .mem_rvalid_i(rvalid & sel),
      .mem_rdata_i(rdata), .mem_err_i(berr));

   logic        o_ready, o_resp_valid, o_resp_err, o_mem_req, o_mem_we;
   logic [63:0] o_resp_rdata, o_mem_wdata;
   logic [31:0] o_mem_addr;
   logic [7:0]  o_mem_be;
   assign o_ready      = sel ? b_ready : a_ready;
   assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
   assign o_resp_err   = sel ? b_resp_err : a_resp_err;
   assign o_resp_rdata = sel ? b_resp_rdata : {32'd0, a_resp_rdata};
   assign o_mem_req    = sel ? b_mem_req : a_mem_req;
   assign o_mem_we     = sel ? b_mem_we : a_mem_we;
   assign o_mem_addr   = sel ? b_mem_addr : a_mem_addr;
   assign o_mem_be     = sel ? b_mem_be : {4'd0, a_mem_be};
   assign o_mem_wdata  = sel ? b_mem_wdata : {32'd0, a_mem_wdata};

   int checks = 0, failures = 0;
   int cyc = 0, resp_cnt = 0, resp_cyc = 0, acc_cyc = 0, exp_cnt = 0, saved = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        err;
      logic [63:0] rdata;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every completion pulse pops the oldest expected response.
   always @(negedge clk) begin
      if (o_resp_valid) begin
         resp_cnt++;
         resp_cyc = cyc;
         chk("resp_expected", 64'(sbq.size() > 0), 64'd1);
         if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("resp_err", 64'(o_resp_err), 64'(mon_e.err));
            chk("resp_rdata", o_resp_rdata, mon_e.rdata);
         end
      end
   end

   task automatic start(input logic w, input logic [2:0] f, input logic [31:0] ad,
                        input logic [63:0] wd, input logic e, input logic [63:0] rd);
      exp_t x;
      chk("ready_idle", 64'(o_ready), 64'd1);
      req_valid = 1'b1; we = w; f3 = f; addr = ad; wdata = wd;
      x.err = e; x.rdata = rd;
      sbq.push_back(x);
      acc_cyc = cyc;
      exp_cnt = resp_cnt + 1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("ready_busy", 64'(o_ready), 64'd0);
   endtask

   task automatic beat(input string tag, input logic [31:0] ea, input logic [7:0] ebe,
                       input logic [63:0] ewd, input int dly, input logic [63:0] rd, input logic er);
      for (int i = 0; i < dly; i++) begin
         chk({tag, "_stall_req"}, 64'(o_mem_req), 64'd1);
         chk({tag, "_stall_addr"}, 64'(o_mem_addr), 64'(ea));
         chk({tag, "_stall_be"}, 64'(o_mem_be), 64'(ebe));
         @(negedge clk);
      end
      chk({tag, "_req"}, 64'(o_mem_req), 64'd1);
      chk({tag, "_we"}, 64'(o_mem_we), 64'(we));
      chk({tag, "_addr"}, 64'(o_mem_addr), 64'(ea));
      chk({tag, "_be"}, 64'(o_mem_be), 64'(ebe));
      chk({tag, "_wdata"}, o_mem_wdata, ewd);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      chk({tag, "_wait_req"}, 64'(o_mem_req), 64'd0);
      chk({tag, "_wait_be"}, 64'(o_mem_be), 64'd0);
      rvalid = 1'b1; rdata = rd; berr = er;
      @(negedge clk);
      rvalid = 1'b0; rdata = '0; berr = 1'b0;
   endtask

   task automatic wait_resp(input int lat);
      int n;
      n = 0;
      #1;
      while (resp_cnt < exp_cnt && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("resp_seen", 64'(resp_cnt), 64'(exp_cnt));
      chk("resp_latency", 64'(resp_cyc - acc_cyc), 64'(lat));
      @(negedge clk);
      #1;
      chk("resp_single", 64'(resp_cnt), 64'(exp_cnt));
      chk("ready_back", 64'(o_ready), 64'd1);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_ready_a", 64'(o_ready), 64'd1);
      chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
      chk("rst_mem_req", 64'(o_mem_req), 64'd0);
      chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
      chk("rst_mem_be", 64'(o_mem_be), 64'd0);
      chk("rst_mem_wdata", o_mem_wdata, 64'd0);
      sel = 1'b1;
      #1 chk("rst_ready_b", 64'(o_ready), 64'd1);
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // LB at 0x1003 on the 32-bit instance, zero-wait bus
      start(1'b0, 3'b000, 32'h1003, 64'd0, 1'b0, 64'hFFFF_FF80);
      beat("lb", 32'h1000, 8'h08, 64'd0, 0, 64'h80FF_1234, 1'b0);
      wait_resp(3);

      // SH split across the word boundary
      start(1'b1, 3'b001, 32'h2003, 64'h0000_ABCD, 1'b0, 64'd0);
      beat("sh1", 32'h2000, 8'h08, 64'hCD00_0000, 0, 64'd0, 1'b0);
      beat("sh2", 32'h2004, 8'h01, 64'h0000_00AB, 0, 64'd0, 1'b0);
      wait_resp(5);

      // LW with grant stalled 4 cycles
      start(1'b0, 3'b010, 32'h10, 64'd0, 1'b0, 64'h1234_5678);
      beat("lw_stall", 32'h10, 8'h0F, 64'd0, 4, 64'h1234_5678, 1'b0);
      wait_resp(7);

      // Split LW merge, garbage in the unused lanes
      start(1'b0, 3'b010, 32'h2002, 64'd0, 1'b0, 64'h1234_5678);
      beat("lw_split1", 32'h2000, 8'h0C, 64'd0, 0, 64'h5678_AAAA, 1'b0);
      beat("lw_split2", 32'h2004, 8'h03, 64'd0, 0, 64'hFFFF_1234, 1'b0);
      wait_resp(5);

      // LHU zero-extension
      start(1'b0, 3'b101, 32'h2, 64'd0, 1'b0, 64'h8001);
      beat("lhu", 32'h0, 8'h0C, 64'd0, 0, 64'h8001_0000, 1'b0);
      wait_resp(3);

      // LD on XLEN=32 is illegal: fast error, no bus activity
      start(1'b0, 3'b011, 32'h8, 64'd0, 1'b1, 64'd0);
      chk("ld32_no_req", 64'(o_mem_req), 64'd0);
      wait_resp(1);

      // Misaligned LW with bus error on beat 1: no second beat
      start(1'b0, 3'b010, 32'h1001, 64'd0, 1'b1, 64'd0);
      beat("lw_err1", 32'h1000, 8'h0E, 64'd0, 0, 64'hFFFF_FFFF, 1'b1);
      chk("lw_err_no_beat2", 64'(o_mem_req), 64'd0);
      wait_resp(3);

      // Beat-2 address wraps to zero
      start(1'b1, 3'b001, 32'hFFFF_FFFF, 64'h1234, 1'b0, 64'd0);
      beat("wrap1", 32'hFFFF_FFFC, 8'h08, 64'h3400_0000, 0, 64'd0, 1'b0);
      beat("wrap2", 32'h0000_0000, 8'h01, 64'h0000_0012, 0, 64'd0, 1'b0);
      wait_resp(5);

      // Reset asserted in WAIT1 abandons the access
      start(1'b0, 3'b010, 32'h40, 64'd0, 1'b0, 64'd0);
      chk("rst_mid_req_before", 64'(o_mem_req), 64'd1);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req", 64'(o_mem_req), 64'd0);
      chk("rst_mid_ready", 64'(o_ready), 64'd1);
      void'(sbq.pop_back());
      saved = resp_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk("rst_mid_no_resp", 64'(resp_cnt), 64'(saved));

      start(1'b0, 3'b100, 32'h45, 64'd0, 1'b0, 64'h99);
      beat("lbu_post_rst", 32'h44, 8'h02, 64'd0, 0, 64'h0000_9900, 1'b0);
      wait_resp(3);

      // 64-bit instance, misalignment rejected
      @(negedge clk);
      sel = 1'b1;
      @(negedge clk);
      start(1'b0, 3'b110, 32'h4, 64'd0, 1'b0, 64'h0000_0000_DEAD_BEEF);
      beat("lwu64", 32'h0, 8'hF0, 64'd0, 0, 64'hDEAD_BEEF_0000_0000, 1'b0);
      wait_resp(3);

      start(1'b0, 3'b010, 32'h4, 64'd0, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF);
      beat("lw64", 32'h0, 8'hF0, 64'd0, 0, 64'hDEAD_BEEF_0000_0000, 1'b0);
      wait_resp(3);

      start(1'b1, 3'b011, 32'h8, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0);
      beat("sd64", 32'h8, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 64'd0, 1'b0);
      wait_resp(3);

      start(1'b0, 3'b010, 32'h6, 64'd0, 1'b1, 64'd0);
      chk("mis0_no_req", 64'(o_mem_req), 64'd0);
      wait_resp(1);

      chk("sb_drained", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end
endmodule
